iter_int_mul_ifc: RTL and testbench
===================================

Name: iter_int_mul_ifc

Overview:
Request/response front-end placed directly upstream of the iterative integer multiplier control/datapath pair. It accepts operand pairs over a val/rdy request interface and buffers them in a small FIFO. It issues one operation at a time to the multiplier via a single-cycle op_val pulse with stable operands, waits for mul_commit, captures the product, and presents it on a val/rdy response interface.

Parameters:
WIDTH, 32, operand and product width in bits (product is the low WIDTH bits).
REQ_DEPTH, 2, request FIFO entries; power of two, >= 2.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous active-high reset
req_val  in  1  request valid
req_rdy  out  1  request ready
req_a  in  WIDTH  operand A
req_b  in  WIDTH  operand B
resp_val  out  1  response valid
resp_rdy  in  1  response ready
resp_p  out  WIDTH  product
op_val  out  1  start pulse to multiplier (drives val_op)
op_a  out  WIDTH  operand A to multiplier, registered
op_b  out  WIDTH  operand B to multiplier, registered
mul_commit  in  1  multiplier completion strobe
mul_p  in  WIDTH  multiplier product, valid while mul_commit = 1

Behaviour:
- Reset (synchronous, active-high): FIFO empty, FSM to IDLE; resp_val=0, resp_p=0, op_val=0, op_a=0, op_b=0. req_rdy=0 while reset is asserted.
- Request FIFO: req_rdy = !full. Push on req_val && req_rdy. No bypass: when full, a push is refused even if a pop occurs in the same cycle. Pointers wrap modulo REQ_DEPTH. Occupancy counter is 0..REQ_DEPTH. Push and pop in the same cycle leave occupancy unchanged.
- resp_free = !resp_val || resp_rdy.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if FIFO non-empty && resp_free, pop the head, load op_a/op_b from it, go to ISSUE. Otherwise stay.
  - ISSUE: op_val=1 for exactly this cycle. Go to WAIT.
  - WAIT: op_val=0; op_a/op_b held. On mul_commit, capture mul_p into resp_p, set resp_val=1, go to IDLE.
- op_a/op_b change only on the IDLE->ISSUE transition. They stay stable through the multiplier's LOAD cycle and until commit.
- mul_commit outside WAIT is ignored: no state change, no response.
- Response register: single entry. resp_val clears on resp_val && resp_rdy unless a capture occurs in the same cycle. Capture cannot coincide with an undrained response, because issue requires resp_free.
- resp_p is held stable while resp_val=1 && !resp_rdy.
- Latency with the team's multiplier (issue to commit = 11 cycles), empty pipe:
  - req fire at cycle t
  - pop at t+1
  - op_val at t+2
  - mul_commit at t+13
  - resp_val at t+14
- Back-to-back throughput: one op per 13 cycles when resp_rdy=1. The next op_val occurs 2 cycles after the previous commit, while the multiplier is in IDLE.
- Reset mid-operation aborts the in-flight op; no response is produced. The multiplier shares the same reset.
- Single outstanding multiplier op at all times.

Test Plan:
- Reset then idle: reset high 2 cycles, low -> req_rdy=1, resp_val=0, op_val=0, op_a=op_b=0, FIFO empty.
- Single op: req a=3, b=5 at cycle t, resp_rdy=1 -> op_val pulses at t+2 with op_a=3, op_b=5; resp_val=1 with resp_p=15 at t+14 for one cycle.
- FIFO fill/backpressure: REQ_DEPTH=2, push (2,7),(4,4),(6,6) back-to-back -> first pops at t+1; third accepted only once occupancy < 2; responses 14, 16, 36 in order.
- Response stall: resp_rdy=0, two queued ops -> first result held constant; second op_val not issued until resp_rdy=1 handshake; then second op issues on the next IDLE cycle.
- Spurious commit: pulse mul_commit while in IDLE with FIFO empty -> resp_val stays 0, state stays IDLE.
- Reset mid-op: reset during WAIT (t+8) -> resp_val never asserts for that op; after reset, new req (9,9) yields resp_p=81 at the normal latency.

Source files
------------

// File: rtl/iter_int_mul_ifc.sv
// Request/response front-end for the iterative integer multiplier: buffers
// operand pairs, issues one op at a time with a single-cycle op_val pulse.
module iter_int_mul_ifc #(
  parameter int WIDTH     = 32,
  parameter int REQ_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [WIDTH-1:0] resp_p,
  output logic             op_val,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic             mul_commit,
  input  logic [WIDTH-1:0] mul_p
);

  localparam int PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(REQ_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  logic [WIDTH-1:0] mem_a_q [REQ_DEPTH];
  logic [WIDTH-1:0] mem_b_q [REQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  state_e           state_q, state_d;
  logic             op_val_q, op_val_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             resp_val_q, resp_val_d;
  logic [WIDTH-1:0] resp_p_q, resp_p_d;

  logic fifo_full;
  logic fifo_empty;
  logic resp_free;
  logic push;
  logic pop;
  logic capture;

  assign fifo_full  = (count_q == CNT_W'(REQ_DEPTH));
  assign fifo_empty = (count_q == '0);
  // No bypass: a full FIFO refuses a push even when a pop happens this cycle.
  assign req_rdy    = !reset && !fifo_full;
  assign push       = req_val && req_rdy;
  assign resp_free  = !resp_val_q || resp_rdy;
  assign pop        = (state_q == ST_IDLE) && !fifo_empty && resp_free;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_val_d = 1'b0;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    capture  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d  = ST_ISSUE;
          op_val_d = 1'b1;
          op_a_d   = mem_a_q[rd_ptr_q];
          op_b_d   = mem_b_q[rd_ptr_q];
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Commits seen in any other state are ignored.
        if (mul_commit) begin
          capture = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    resp_val_d = resp_val_q;
    resp_p_d   = resp_p_q;
    if (capture) begin
      resp_val_d = 1'b1;
      resp_p_d   = mul_p;
    end else if (resp_val_q && resp_rdy) begin
      resp_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= req_a;
      mem_b_q[wr_ptr_q] <= req_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      op_val_q   <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      resp_val_q <= 1'b0;
      resp_p_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      op_val_q   <= op_val_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      resp_val_q <= resp_val_d;
      resp_p_q   <= resp_p_d;
    end
  end

  assign op_val   = op_val_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign resp_val = resp_val_q;
  assign resp_p   = resp_p_q;

endmodule

// File: tb/tb_iter_int_mul_ifc.sv
// Scoreboard bench for iter_int_mul_ifc with a behavioural 11-cycle multiplier
// model; expected products come from the request operands.
module tb_iter_int_mul_ifc;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_p;
  logic        op_val;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mul_commit;
  logic [31:0] mul_p;

  logic        mcommit;
  logic [31:0] prod;
  logic [3:0]  cnt;
  logic [31:0] op_a_s, op_b_s;
  logic        spur;
  logic [31:0] spur_p;

  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  iter_int_mul_ifc #(.WIDTH(32), .REQ_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_p(resp_p),
    .op_val(op_val), .op_a(op_a), .op_b(op_b),
    .mul_commit(mul_commit), .mul_p(mul_p)
  );

  always #5 clk = ~clk;

  // Multiplier model: commit arrives 11 cycles after the op_val cycle.
  always @(posedge clk) begin
    if (reset) begin
      cnt     <= 4'd0;
      mcommit <= 1'b0;
    end else begin
      cnt     <= op_val ? 4'd10 : ((cnt != 4'd0) ? cnt - 4'd1 : 4'd0);
      mcommit <= (cnt == 4'd1);
      if (op_val) begin
        prod   <= op_a * op_b;
        op_a_s <= op_a;
        op_b_s <= op_b;
      end
    end
  end

  assign mul_commit = mcommit | spur;
  assign mul_p      = mcommit ? prod : spur_p;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Response monitor / scoreboard.
  initial begin
    logic        stall_prev;
    logic [31:0] stall_p;
    stall_prev = 1'b0;
    stall_p    = 32'd0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_val", 32'(resp_val), 32'd1);
          check("hold_p", resp_p, stall_p);
        end
        if (resp_val && resp_rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected: got %0h expected none", resp_p);
          end else begin
            check("resp_p", resp_p, exp_q.pop_front());
          end
        end
        if (op_val) check("single_outstanding", 32'(cnt), 32'd0);
        if (cnt != 4'd0) begin
          check("op_a_stable", op_a, op_a_s);
          check("op_b_stable", op_b, op_b_s);
        end
        stall_prev = resp_val && !resp_rdy;
        stall_p    = resp_p;
      end
    end
  end

  task automatic run_latency(input logic [31:0] a, input logic [31:0] b);
    req_a   = a;
    req_b   = b;
    req_val = 1'b1;
    #1;
    check("lat_req_rdy", 32'(req_rdy), 32'd1);
    exp_q.push_back(a * b);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) req_val = 1'b0;
      #1;
      check("lat_op_val", 32'(op_val), 32'(k == 2));
      check("lat_resp_val", 32'(resp_val), 32'(k == 14));
      if (k == 2) begin
        check("lat_op_a", op_a, a);
        check("lat_op_b", op_b, b);
      end
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n;
    req_a   = a;
    req_b   = b;
    req_val = 1'b1;
    #1;
    n = 0;
    while (!req_rdy && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got req_rdy=0 expected 1");
      req_val = 1'b0;
    end else begin
      exp_q.push_back(a * b);
      @(negedge clk);
      req_val = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    resp_rdy = 1'b1;
    req_val  = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || resp_val) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    req_val  = 1'b0;
    req_a    = 32'd0;
    req_b    = 32'd0;
    resp_rdy = 1'b1;
    spur     = 1'b0;
    spur_p   = 32'd0;

    repeat (2) @(negedge clk);
    #1;
    check("rdy_in_reset", 32'(req_rdy), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_req_rdy", 32'(req_rdy), 32'd1);
    check("rst_resp_val", 32'(resp_val), 32'd0);
    check("rst_op_val", 32'(op_val), 32'd0);
    check("rst_op_a", op_a, 32'd0);
    check("rst_op_b", op_b, 32'd0);
    check("rst_resp_p", resp_p, 32'd0);

    @(negedge clk);
    run_latency(32'd3, 32'd5);

    // Back-to-back fill with the FIFO at depth 2.
    send(32'd2, 32'd7);
    send(32'd4, 32'd4);
    send(32'd6, 32'd6);
    wait_drain(200);

    // Response stall: result held, no new issue until the handshake.
    resp_rdy = 1'b0;
    send(32'd5, 32'd5);
    send(32'd6, 32'd7);
    send(32'd8, 32'd2);
    n = 0;
    #1;
    while (!resp_val && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("stall_resp_val", 32'(resp_val), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("stall_no_issue", 32'(op_val), 32'd0);
      check("stall_full", 32'(req_rdy), 32'd0);
    end
    @(negedge clk);
    resp_rdy = 1'b1;
    #1;
    check("hs_no_issue_yet", 32'(op_val), 32'd0);
    @(negedge clk);
    #1;
    check("hs_issue_next", 32'(op_val), 32'd1);
    check("hs_resp_cleared", 32'(resp_val), 32'd0);
    check("hs_rdy_after_pop", 32'(req_rdy), 32'd1);
    wait_drain(200);

    // Spurious commit while idle with an empty FIFO.
    spur   = 1'b1;
    spur_p = 32'h1234_5678;
    @(negedge clk);
    spur = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("spur_resp_val", 32'(resp_val), 32'd0);
      check("spur_op_val", 32'(op_val), 32'd0);
      @(negedge clk);
    end
    run_latency(32'd11, 32'd13);

    // Reset during WAIT aborts the op.
    req_a   = 32'd7;
    req_b   = 32'd3;
    req_val = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) req_val = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      check("abort_resp_val", 32'(resp_val), 32'd0);
      @(negedge clk);
    end
    run_latency(32'd9, 32'd9);

    // Randomized traffic with random response backpressure.
    repeat (600) begin
      @(negedge clk);
      req_val  = 1'($urandom_range(0, 1));
      req_a    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
      req_b    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
      resp_rdy = ($urandom_range(0, 3) != 0);
      #1;
      if (req_val && req_rdy) exp_q.push_back(req_a * req_b);
    end
    @(negedge clk);
    wait_drain(2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
